// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit in front of a word-wide data memory.
// Sub-word stores go through read-modify-write. Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned H/HU/W.
module dmem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WORD_WR = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_WR  = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  state_e            state_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        funct3_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [31:0]       mem_wd_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic              bad_funct3_s;
  logic              misalign_s;
  logic              req_err_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    // f3[2] selects zero extension (BU/HU)
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic is_half, input logic [1:0] lo,
                                              input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (is_half) begin
      if (lo[1]) r[31:16] = wd;
      else       r[15:0]  = wd;
    end else begin
      case (lo)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  // Unsupported funct3 decode for the incoming request
  always_comb begin
    bad_funct3_s = 1'b0;
    if (req_we_i) begin
      bad_funct3_s = (req_funct3_i != 3'b000) && (req_funct3_i != 3'b001) &&
                     (req_funct3_i != 3'b010);
    end else begin
      case (req_funct3_i)
        3'b011, 3'b110, 3'b111: bad_funct3_s = 1'b1;
        default:                bad_funct3_s = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // Alignment check on the incoming request
  always_comb begin
    case (req_funct3_i[1:0])
      2'b01:   misalign_s = req_addr_i[0];
      2'b10:   misalign_s = |req_addr_i[1:0];
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign req_err_s = bad_funct3_s | misalign_s;

  // Request FSM with registered response and memory address/data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      wdata_q      <= 16'h0000;
      mem_a_q      <= '0;
      mem_wd_q     <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_lo_q <= req_addr_i[1:0];
            funct3_q  <= req_funct3_i;
            wdata_q   <= req_wdata_i[15:0];
            if (req_err_s) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else begin
              mem_a_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
              if (!req_we_i) begin
                state_q <= S_LOAD;
              end else if (req_funct3_i == 3'b010) begin
                state_q  <= S_WORD_WR;
                mem_wd_q <= req_wdata_i;
              end else begin
                state_q <= S_RMW_RD;
              end
            end
          end
        end
        S_LOAD: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= load_extract(funct3_q, addr_lo_q, mem_rd_i);
        end
        S_RMW_RD: begin
          state_q  <= S_RMW_WR;
          mem_wd_q <= merge_store(funct3_q[0], addr_lo_q, mem_rd_i, wdata_q);
        end
        S_WORD_WR, S_RMW_WR: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is gated by reset so a reset in a write state blocks the write
  assign mem_we_o     = ((state_q == S_WORD_WR) || (state_q == S_RMW_WR)) && !reset_i;
  assign req_ready_o  = (state_q == S_IDLE) && !reset_i;
  assign mem_a_o      = mem_a_q;
  assign mem_wd_o     = mem_wd_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: byte-array reference model, directed examples, random traffic.
// Honours LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;
  logic [7:0]  ref_b [0:1023];
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_a_o(mem_a), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[9:2]] <= mem_wd;
    else if (pre_we) mem[pre_idx]    <= pre_dat;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    return {ref_b[4*widx+3], ref_b[4*widx+2], ref_b[4*widx+1], ref_b[4*widx]};
  endfunction

  // Reference: architectural effect of one request on a byte-addressed memory
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output int lat);
    int size;
    int base;
    longint unsigned v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (we) err = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    err = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
    if (!err && (int'(addr) % size) != 0) err = 1'b1;
`endif
    base = int'(addr) - (int'(addr) % size);
    rd = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v | (longint'(ref_b[base + i]) << (8 * i));
      if (size < 4 && !f3[2] && v[8 * size - 1]) v = v - (64'd1 << (8 * size));
      rd  = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) ref_b[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  // Issue one request from a negedge and check the whole transaction
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          lat;
    int          wes;
    int          w;
    model(we, f3, addr, wd, e_err, e_rd, e_lat);
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wes = 0;
    while (!resp_valid && lat < 8) begin
      if (mem_we) begin
        wes++;
        chk("mem_a", mem_a, addr & 32'hFFFF_FFFC);
      end
      @(negedge clk);
      lat++;
    end
    got = resp_rdata;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("we_count", 32'(wes), (we && !e_err) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("pulse_end", 32'(resp_valid), 32'd0);
  endtask

  initial begin : main
    logic [31:0] got;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          hs;
    int          pulses;
    int          last;
    logic [31:0] word40;
    logic        rwe;
    logic [2:0]  rf3;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 8'h00; pre_dat = 32'h0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 256; i++) begin
      pre_we = 1'b1; pre_idx = 8'(i); pre_dat = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4 * i + k] = 8'((pre_dat >> (8 * k)) & 32'hFF);
      @(negedge clk);
    end
    pre_we = 1'b0;
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    @(negedge clk);

    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got);
    chk("lw_10", got, 32'hDEADBEEF);

    do_req(1'b1, 3'b010, 32'h20, 32'h8040C0FF, got);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, got);  chk("lb_20", got, 32'hFFFFFFFF);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, got);  chk("lbu_23", got, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, got);  chk("lh_22", got, 32'hFFFF8040);
    do_req(1'b0, 3'b101, 32'h20, 32'h0, got);  chk("lhu_20", got, 32'h0000C0FF);

    do_req(1'b1, 3'b010, 32'h30, 32'h11223344, got);
    do_req(1'b1, 3'b000, 32'h31, 32'h000000AB, got);
    do_req(1'b1, 3'b001, 32'h32, 32'h00005566, got);
    do_req(1'b0, 3'b010, 32'h30, 32'h0, got);  chk("rmw_30", got, 32'h5566AB44);

    do_req(1'b0, 3'b011, 32'h10, 32'h0, got);  chk("bad_f3_rdata", got, 32'h0);
    do_req(1'b1, 3'b010, 32'h40, 32'h12345678, got);
    do_req(1'b0, 3'b010, 32'h42, 32'h0, got);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_42", got, 32'h0);
`else
    chk("lw_42", got, 32'h12345678);
`endif

    // Six back-to-back LWs with req_valid held high
    model(1'b0, 3'b010, 32'h10, 32'h0, e_err, e_rd, e_lat);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    hs = 0; pulses = 0; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid) begin
        pulses++;
        chk("b2b_rdata", resp_rdata, 32'hDEADBEEF);
        chk("b2b_ready_in_resp", 32'(req_ready), 32'd0);
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd3);
        last = c;
      end
      if (req_valid && req_ready) hs++;
      if (hs == 6 && !req_ready) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd6);

    // Reset during the write cycle of an SB must drop the request
    word40 = ref_word(16);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_wr_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_blocks_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    #1;
    chk("rst_ready_next", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rst_no_resp2", 32'(resp_valid), 32'd0);
    chk("rst_word_kept", mem[16], word40);

    for (int n = 0; n < 200; n++) begin
      rwe = 1'($urandom_range(1, 0));
      if ($urandom_range(99, 0) < 15) rf3 = 3'($urandom_range(7, 0));
      else if (rwe)                   rf3 = 3'($urandom_range(2, 0));
      else begin
        rf3 = 3'($urandom_range(4, 0));
        if (rf3 == 3'd3) rf3 = 3'd5;
      end
      do_req(rwe, rf3, 32'($urandom_range(1023, 0)), $urandom, got);
    end

    for (int i = 0; i < 256; i++) chk("mem_image", mem[i], ref_word(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
